// File: rtl/block_transmit_sd.sv
// SPI-mode SD single-block write: gap, start token, 512 data bytes from the sector cache, CRC,
// data-response check and busy wait. Optional serial CRC16-CCITT generation under `CRC16_EN.
module block_transmit_sd #(
    parameter int GAP_BITS     = 8,
    parameter int RESP_TIMEOUT = 64,
    parameter int BUSY_TIMEOUT = 65535
) (
    input  logic        clk400,
    input  logic        reset,
    input  logic        enable,
    input  logic        SDin,
    input  logic [15:0] casheValue,
    output logic [7:0]  casheAddress,
    output logic        readCashe,
    output logic        SDout,
    output logic        done,
    output logic        error,
    output logic [2:0]  response
);

    typedef enum logic [2:0] {
        IDLE, GAP, TOKEN, DATA, CRC, RESP_WAIT, RESP_BITS, BUSY
    } state_t;

    localparam logic [7:0]  TOKEN_BYTE = 8'hFE;
    localparam logic [11:0] GAP_LAST   = 12'(GAP_BITS - 1);
    localparam logic [15:0] RESP_LAST  = 16'(RESP_TIMEOUT - 1);
    localparam logic [15:0] BUSY_LAST  = 16'(BUSY_TIMEOUT - 1);

    state_t      r_state, w_next;
    logic [11:0] r_cnt;
    logic [15:0] r_tmo;
    logic [15:0] r_shift;
    logic [2:0]  r_rsp;
    logic [7:0]  r_addr;
    logic        r_sdout;
    logic        r_error;
    logic [2:0]  r_response;
    logic        w_load;
    logic        w_bit;

`ifdef CRC16_EN
    logic [15:0] r_crc;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      if (enable) w_next = GAP;
            GAP:       if (r_cnt == GAP_LAST) w_next = TOKEN;
            TOKEN:     if (r_cnt == 12'd7) w_next = DATA;
            DATA:      if (r_cnt == 12'hFFF) w_next = CRC;
            CRC:       if (r_cnt == 12'd15) w_next = RESP_WAIT;
            RESP_WAIT: begin
                if (!SDin)                   w_next = RESP_BITS;
                else if (r_tmo == RESP_LAST) w_next = IDLE;
            end
            RESP_BITS: if (r_cnt == 12'd3) w_next = (r_rsp == 3'b010) ? BUSY : IDLE;
            BUSY:      if (SDin || r_tmo == BUSY_LAST) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    // Word fetch happens on the last token cycle and on the last bit of every word but the final one;
    // the address register already points at the word being fetched.
    always_comb begin
        w_load = 1'b0;
        w_bit  = 1'b1;
        case (r_state)
            TOKEN: begin
                w_bit  = TOKEN_BYTE[~r_cnt[2:0]];
                w_load = (r_cnt == 12'd7);
            end
            DATA: begin
                w_bit  = r_shift[15];
                w_load = (r_cnt[3:0] == 4'hF) && (r_cnt != 12'hFFF);
            end
`ifdef CRC16_EN
            CRC:     w_bit = r_crc[15];
`endif
            default: w_bit = 1'b1;
        endcase
    end

    always_ff @(posedge clk400) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_shift    <= '0;
            r_rsp      <= '0;
            r_addr     <= '0;
            r_sdout    <= 1'b1;
            r_error    <= 1'b0;
            r_response <= 3'b000;
        end else begin
            r_state <= w_next;
            r_sdout <= w_bit;

            // Counters restart on every state change so each state sees a count from zero.
            if (w_next != r_state || r_state == IDLE) begin
                r_cnt <= '0;
                r_tmo <= '0;
            end else begin
                r_cnt <= r_cnt + 12'd1;
                r_tmo <= r_tmo + 16'd1;
            end

            if (w_load) begin
                r_shift <= casheValue;
                r_addr  <= r_addr + 8'd1;
            end else if (r_state == DATA) begin
                r_shift <= {r_shift[14:0], 1'b0};
            end
            if (r_state == IDLE) r_addr <= '0;

            if (r_state == IDLE && enable) r_error <= 1'b0;

            if (r_state == RESP_WAIT && SDin && r_tmo == RESP_LAST) begin
                r_response <= 3'b111;
                r_error    <= 1'b1;
            end

            if (r_state == RESP_BITS) begin
                if (r_cnt == 12'd3) begin
                    r_response <= r_rsp;
                    if (r_rsp != 3'b010) r_error <= 1'b1;
                end else begin
                    r_rsp <= {r_rsp[1:0], SDin};
                end
            end

            if (r_state == BUSY && !SDin && r_tmo == BUSY_LAST) begin
                r_response <= 3'b111;
                r_error    <= 1'b1;
            end
        end
    end

`ifdef CRC16_EN
    always_ff @(posedge clk400) begin
        if (reset)
            r_crc <= '0;
        else if (r_state == IDLE && enable)
            r_crc <= '0;
        else if (r_state == DATA)
            r_crc <= {r_crc[14:0], 1'b0} ^ ((r_crc[15] ^ r_shift[15]) ? 16'h1021 : 16'h0000);
        else if (r_state == CRC)
            r_crc <= {r_crc[14:0], 1'b0};
    end
`endif

    assign casheAddress = r_addr;
    assign readCashe    = w_load;
    assign SDout        = r_sdout;
    assign done         = (r_state == IDLE);
    assign error        = r_error;
    assign response     = r_response;

endmodule
